// File: rtl/sha3_scan_scheduler.sv
// Nonce-scan sequencer in front of the iterating SHA3 pipe: issues template states with
// the nonce lane rewritten, pads partial bursts, and pairs returning results with nonces.
module sha3_scan_scheduler #(
   parameter int NONCE_LANE = 19,
   parameter int FLAG_DEPTH = 16
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [1599:0] cfg_tmpl,
   input  logic [63:0]   cfg_nonce,
   input  logic [31:0]   cfg_count,
   input  logic [63:0]   cfg_target,
   input  logic          pipe_gimme,
   output logic          pipe_sample,
   output logic [1599:0] pipe_state,
   input  logic          pipe_good,
   input  logic [63:0]   pipe_oa0,
   output logic          found_valid,
   input  logic          found_ready,
   output logic [63:0]   found_nonce,
   output logic [63:0]   found_hash,
   output logic          busy,
   output logic          done,
   output logic          err_overflow,
   output logic          err_orphan
);

   localparam int PTR_W = (FLAG_DEPTH > 1) ? $clog2(FLAG_DEPTH) : 1;
   localparam int CNT_W = $clog2(FLAG_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
   state_t state, state_nxt;

   logic [1599:0]          tmpl;
   logic [63:0]            target;
   logic [63:0]            next_nonce;
   logic [63:0]            res_nonce;
   logic [31:0]            rem;
   logic                   burst_on;
   logic [FLAG_DEPTH-1:0]  flags;
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       fifo_cnt;
   logic                   accept, issue, valid_slot, pop, pop_flag, hit, slot_free, done_set;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FLAG_DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign cfg_ready   = (state == IDLE);
   assign busy        = (state != IDLE);
   assign accept      = cfg_valid & cfg_ready;
   assign valid_slot  = (rem != 32'd0);
   // A burst opens only with nonces left, then runs (padding if needed) until gimme drops.
   assign pipe_sample = (state == FEED) & (burst_on | (pipe_gimme & valid_slot));
   assign issue       = pipe_sample & pipe_gimme;
   assign pop         = pipe_good & (fifo_cnt != '0);
   assign pop_flag    = flags[rd_ptr];
   assign hit         = pop & pop_flag & (pipe_oa0 <= target);
   assign slot_free   = ~found_valid | found_ready;

   always_comb begin
      pipe_state = tmpl;
      if (valid_slot) pipe_state[NONCE_LANE*64 +: 64] = next_nonce;
   end

   always_comb begin
      state_nxt = state;
      done_set  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (cfg_count == 32'd0) done_set = 1'b1;
               else                    state_nxt = FEED;
            end
         end
         FEED: begin
            if (!valid_slot && !burst_on && pipe_gimme) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (fifo_cnt == '0) begin
               state_nxt = IDLE;
               done_set  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         burst_on     <= 1'b0;
         rem          <= 32'd0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_cnt     <= '0;
         found_valid  <= 1'b0;
         done         <= 1'b0;
         err_overflow <= 1'b0;
         err_orphan   <= 1'b0;
      end else begin
         done <= done_set;
         if (state == FEED) begin
            if (!burst_on && pipe_gimme && valid_slot) burst_on <= 1'b1;
            else if (burst_on && !pipe_gimme)          burst_on <= 1'b0;
         end
         if (accept)                   rem <= cfg_count;
         else if (issue && valid_slot) rem <= rem - 32'd1;
         if (issue) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)   rd_ptr <= ptr_inc(rd_ptr);
         if (issue && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
         else if (!issue && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
         if (pipe_good && fifo_cnt == '0) err_orphan <= 1'b1;
         if (hit && !slot_free)           err_overflow <= 1'b1;
         if (hit && slot_free)                found_valid <= 1'b1;
         else if (found_valid && found_ready) found_valid <= 1'b0;
      end
   end

   // Datapath registers carry no reset; they are loaded at accept or on issue/pop.
   always_ff @(posedge clk) begin
      if (accept) begin
         tmpl       <= cfg_tmpl;
         target     <= cfg_target;
         next_nonce <= cfg_nonce;
         res_nonce  <= cfg_nonce;
      end else begin
         if (issue && valid_slot) next_nonce <= next_nonce + 64'd1;
         if (pop && pop_flag)     res_nonce  <= res_nonce + 64'd1;
      end
      if (issue) flags[wr_ptr] <= valid_slot;
      if (hit && slot_free) begin
         found_nonce <= res_nonce;
         found_hash  <= pipe_oa0;
      end
   end

   a_flag_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(issue && !pop && fifo_cnt == CNT_W'(FLAG_DEPTH)));

endmodule
